// File: rtl/bit_scan_unit_pkg.sv
// rtl/bit_scan_unit_pkg.sv - op codes, state encoding and scan-width helpers for bit_scan_unit
package bit_scan_pkg;

  typedef enum logic [1:0] {
    OP_FF1 = 2'b00,
    OP_FL1 = 2'b01,
    OP_CLZ = 2'b10,
    OP_CTZ = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_SCAN_WIDTH = 4;
  localparam int NUM_CHUNKS = 32 / DEFAULT_SCAN_WIDTH;

  function automatic bit scan_width_legal(input int w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8) || (w == 16) || (w == 32);
  endfunction

  function automatic int num_chunks(input int w);
    return 32 / w;
  endfunction

  // fl1/clz look for the highest one, so they walk down from the MSB
  function automatic logic msb_first(input op_e op);
    return (op == OP_FL1) || (op == OP_CLZ);
  endfunction

  function automatic logic [31:0] map_result(input op_e op, input logic found, input logic [4:0] p);
    case (op)
      OP_FF1, OP_FL1: return found ? (32'(p) + 32'd1) : 32'd0;
      OP_CLZ:         return found ? (32'd31 - 32'(p)) : 32'd32;
      default:        return found ? 32'(p) : 32'd32;
    endcase
  endfunction

endpackage

// File: rtl/bit_scan_unit_if.sv
// rtl/bit_scan_unit_if.sv - start/busy/done request interface of bit_scan_unit
interface bit_scan_unit_if;
  logic        start;
  logic [1:0]  control;
  logic [31:0] operand;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zeroFlag;

  modport master (output start, control, operand, input busy, done, result, zeroFlag);
  modport slave  (input start, control, operand, output busy, done, result, zeroFlag);
endinterface

// File: rtl/bit_scan_unit_chunk_priority_encoder.sv
// rtl/bit_scan_unit_chunk_priority_encoder.sv - hit flag and in-chunk index of the lowest or highest set bit
module chunk_priority_encoder #(
  parameter int W     = 4,
  parameter int IDX_W = 2
) (
  input  logic [W-1:0]     chunk_bits,
  input  logic             msb_first,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    hit = |chunk_bits;
    idx = '0;
    if (msb_first) begin
      for (int i = 0; i < W; i++) begin
        if (chunk_bits[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (chunk_bits[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bit_scan_unit.sv
// rtl/bit_scan_unit.sv - iterative ff1/fl1/clz/ctz unit, SCAN_WIDTH bits per cycle
// BIT_SCAN_EARLY_EXIT_EN: leave SCAN at the first chunk holding a one (data-dependent latency).
module bit_scan_unit #(
  parameter int SCAN_WIDTH = bit_scan_pkg::DEFAULT_SCAN_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  bit_scan_unit_if.slave bus
);
  import bit_scan_pkg::*;

  localparam int N_CHUNKS = num_chunks(SCAN_WIDTH);
  localparam int CHUNK_W  = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int IDX_W    = (SCAN_WIDTH > 1) ? $clog2(SCAN_WIDTH) : 1;

  if (!scan_width_legal(SCAN_WIDTH)) begin : g_illegal_width
    $error("SCAN_WIDTH must be 1, 2, 4, 8, 16 or 32");
  end

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [31:0]          operand_q, operand_d;
  logic [CHUNK_W-1:0]   chunk_q, chunk_d;
  logic                 hit_found_q, hit_found_d;
  logic [4:0]           hit_pos_q, hit_pos_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [31:0]          result_q, result_d;
  logic                 zero_flag_q, zero_flag_d;

  logic                 dir_msb;
  logic [4:0]           base;
  logic [31:0]          shifted;
  logic [SCAN_WIDTH-1:0] chunk_bits;
  logic                 cur_hit;
  logic [IDX_W-1:0]     cur_idx;
  logic [4:0]           cur_pos;
  logic                 last_chunk;
  logic                 scan_exit;
  logic                 final_found;
  logic [4:0]           final_pos;

  // base is the bit index of the chunk's LSB in either scan direction
  always_comb begin
    dir_msb = msb_first(op_q);
    if (dir_msb) base = 5'(32 - (int'(chunk_q) + 1) * SCAN_WIDTH);
    else         base = 5'(int'(chunk_q) * SCAN_WIDTH);
    shifted     = operand_q >> base;
    chunk_bits  = shifted[SCAN_WIDTH-1:0];
    cur_pos     = base + 5'(cur_idx);
    last_chunk  = (chunk_q == CHUNK_W'(N_CHUNKS - 1));
    final_found = hit_found_q | cur_hit;
    final_pos   = hit_found_q ? hit_pos_q : cur_pos;
`ifdef BIT_SCAN_EARLY_EXIT_EN
    scan_exit   = last_chunk | cur_hit;
`else
    scan_exit   = last_chunk;
`endif
  end

  chunk_priority_encoder #(
    .W     (SCAN_WIDTH),
    .IDX_W (IDX_W)
  ) u_chunk_priority_encoder (
    .chunk_bits (chunk_bits),
    .msb_first  (dir_msb),
    .hit        (cur_hit),
    .idx        (cur_idx)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    operand_d   = operand_q;
    chunk_d     = chunk_q;
    hit_found_d = hit_found_q;
    hit_pos_d   = hit_pos_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    zero_flag_d = zero_flag_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d     = SCAN;
          op_d        = op_e'(bus.control);
          operand_d   = bus.operand;
          chunk_d     = '0;
          hit_found_d = 1'b0;
          hit_pos_d   = '0;
          busy_d      = 1'b1;
        end
      end
      SCAN: begin
        // only the first hit in scan order is kept when walking every chunk
        if (!hit_found_q && cur_hit) begin
          hit_found_d = 1'b1;
          hit_pos_d   = cur_pos;
        end
        if (scan_exit) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          result_d    = map_result(op_q, final_found, final_pos);
          zero_flag_d = ~final_found;
        end else begin
          chunk_d = chunk_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_FF1;
      operand_q   <= '0;
      chunk_q     <= '0;
      hit_found_q <= 1'b0;
      hit_pos_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      zero_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      operand_q   <= operand_d;
      chunk_q     <= chunk_d;
      hit_found_q <= hit_found_d;
      hit_pos_q   <= hit_pos_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.zeroFlag = zero_flag_q;

endmodule

// File: doc/bit_scan_unit.md
Name: bit_scan_unit

Overview:
- Iterative bit-position unit for the core's execute stage.
- It performs the reverse of the shifter: given a value, it returns a shift distance or bit position instead of applying one.
- Supports find-first-one, find-last-one, count-leading-zeros and count-trailing-zeros, for ff1/fl1-class instructions and for normalisation.
- Multi-cycle with a start/busy/done handshake; examines SCAN_WIDTH bits per cycle to keep area small.

Parameters:
SCAN_WIDTH, 4, bits examined per cycle; legal values 1, 2, 4, 8, 16, 32 (must divide 32)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request pulse; sampled only when busy=0
control  in  2  00 ff1, 01 fl1, 10 clz, 11 ctz
operand  in  32  value to scan; captured when start is accepted
busy  out  1  high while a scan is in progress
done  out  1  one-cycle pulse; result valid from this cycle on
result  out  32  answer, zero-extended; held until the next accepted start
zeroFlag  out  1  operand was all zeros; same timing as result

Behaviour:
- One clock and one reset. Reset is synchronous and active-high. The ports are named clock and reset.
- Reset values: busy=0, done=0, result=0, zeroFlag=0, state IDLE.
- States:
  - IDLE: start=1 → latch operand and control, clear chunk index, go to SCAN.
  - SCAN: each cycle examine chunk k. ff1/ctz scan from the LSB: chunk k covers bits k*W..k*W+W-1. fl1/clz scan from the MSB: chunk k covers bits 31-k*W down to 32-(k+1)*W.
  - SCAN exit: on hit (per Optional Feature), or after chunk 32/W-1, register result and go to DONE.
  - DONE: done=1 for exactly one cycle, then return to IDLE. start in DONE is accepted exactly as in IDLE (back-to-back operations).
- busy=1 in SCAN only.
- Result rules, where p is the bit index 0..31 of the relevant one-bit:
  - ff1: lowest p+1; 0 if operand=0.
  - fl1: highest p+1; 0 if operand=0.
  - clz: 31-highest p; 32 if operand=0.
  - ctz: lowest p; 32 if operand=0.
  - zeroFlag=1 iff the captured operand was 0.
- The first hit found in scan order wins. Within a chunk, the lowest set bit wins for ff1/ctz and the highest for fl1/clz.
- Latency is measured from the clock edge that accepts start to the cycle where done=1:
  - hit in chunk k: k+2 cycles with early exit;
  - otherwise always 32/W+1 cycles.
- start while busy=1: ignored. Neither the latched operand nor control changes.
- operand and control changing after acceptance: no effect.
- Reset asserted mid-SCAN or in DONE: next cycle IDLE with every output at its reset value. No done pulse is produced for the aborted operation.
- result and zeroFlag hold their last values through IDLE. They update only in the cycle that done rises.

Optional Feature:
- Macro: BIT_SCAN_EARLY_EXIT_EN.
- Defined: SCAN leaves as soon as a chunk contains a one, giving data-dependent latency k+2.
- Undefined: SCAN always walks all 32/SCAN_WIDTH chunks and keeps the first hit found. Latency is fixed at 32/SCAN_WIDTH+1 for all operands, so a fixed-latency pipeline stall can be used.
- Results are identical in both builds.

Decomposition:
- Package bit_scan_pkg holds:
  - op code constants OP_FF1, OP_FL1, OP_CLZ, OP_CTZ;
  - the state encoding IDLE, SCAN, DONE;
  - the constant NUM_CHUNKS = 32/SCAN_WIDTH and a legality check on SCAN_WIDTH.
- Sub-module chunk_priority_encoder: combinational over SCAN_WIDTH bits.
  - Inputs: direction select.
  - Outputs: hit flag and in-chunk index.
  - Instantiated once; the top module adds the chunk offset and applies the per-op result mapping.

Test Plan:
- W=4, early exit: ff1 operand 0x00000001 → result 1, zeroFlag 0, done 2 cycles after start. fl1 0x80000000 → result 32, same latency.
- W=4, early exit: ctz 0x00010000 → 16, done at cycle 6. fl1 0x00010000 → 17, done at cycle 5. clz 0x00010000 → 15, done at cycle 5.
- Operand 0x00000000, all four ops:
  - ff1 and fl1 → 0;
  - clz and ctz → 32;
  - zeroFlag=1 and done at cycle 9, in both builds.
- Macro undefined, ff1 0x00000001 → result 1, done at cycle 9. Pulse start again in the DONE cycle with ctz 0x80000000 → 31, done 9 cycles later.
- start asserted during SCAN with a different operand → ignored: the first result is unchanged and exactly one done pulse occurs.
- Reset asserted in cycle 3 of a fl1 0x00000001 scan → outputs 0 the following cycle, no done pulse, and the next start operates normally.
